// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, with a one-word holding buffer
// so consecutive words stream out without a gap.
module shift_reg_piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sdo_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             accept;
  logic             last_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  // On the last-bit edge a buffered word wins over a fresh accept; the buffer
  // is full there, so din_ready is already low and no accept can collide.
  always_comb begin
    accept      = din_valid & ~hold_full_q;
    last_bit    = (cnt_q == CW'(WIDTH - 1));
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
          if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end else begin
          done_d = 1'b1;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (accept) begin
            shift_d = din;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    din_ready = ~hold_full_q;
    sdo_en    = (state_q == SHIFT);
    sdo       = (state_q == SHIFT) & shift_q[WIDTH-1];
    busy      = (state_q == SHIFT) | hold_full_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Scoreboard bench: accepted words queue their expected bits and words; a
// negedge monitor checks sdo, a loopback receiver and every done pulse.
module tb_shift_reg_piso_tx;

  logic       clk = 1'b0;
  logic       resetN;
  logic [3:0] din;
  logic       dinValid;
  logic       dinReady, sdo, sdoEn, busy, done;
  logic [7:0] din8;
  logic       dinValid8;
  logic       dinReady8, sdo8, sdoEn8, busy8, done8;

  int   checks = 0;
  int   errors = 0;
  logic bitQ[$];
  logic [3:0] wordQ[$];
  logic [3:0] rxWord = 4'h0;
  int   enCycles = 0;
  int   enRuns = 0;
  int   doneCount = 0;
  logic prevEn = 1'b0;
  logic prevDone = 1'b0;

  always #5 clk = ~clk;

  shift_reg_piso_tx #(.WIDTH(4)) dut (
    .clk(clk), .reset_n(resetN), .din(din), .din_valid(dinValid),
    .din_ready(dinReady), .sdo(sdo), .sdo_en(sdoEn), .busy(busy), .done(done)
  );

  shift_reg_piso_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(resetN), .din(din8), .din_valid(dinValid8),
    .din_ready(dinReady8), .sdo(sdo8), .sdo_en(sdoEn8), .busy(busy8), .done(done8)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event missing or unexpected", name);
  endtask

  // Loopback SIPO receiver fed by sdo
  always @(posedge clk) begin
    if (sdoEn) rxWord <= {rxWord[2:0], sdo};
  end

  // Monitor: pops expected bits and words as the DUT presents them
  always @(negedge clk) begin
    if (resetN) begin
      if (sdoEn) begin
        if (bitQ.size() == 0) failNow("bit_underflow");
        else checkOutput("sdo_bit", 32'(sdo), 32'(bitQ.pop_front()));
        enCycles++;
        if (!prevEn) enRuns++;
      end else begin
        checkOutput("sdo_idle_zero", 32'(sdo), 32'd0);
      end
      if (done) begin
        doneCount++;
        if (prevDone) failNow("done_two_cycles");
        if (wordQ.size() == 0) failNow("word_underflow");
        else checkOutput("rx_word", 32'(rxWord), 32'(wordQ.pop_front()));
      end
      prevEn   = sdoEn;
      prevDone = done;
    end else begin
      prevEn   = 1'b0;
      prevDone = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [3:0] word, output int waits);
    bit got;
    din      = word;
    dinValid = 1'b1;
    waits    = 0;
    got      = 1'b0;
    while (!got) begin
      @(negedge clk);
      if (dinReady) got = 1'b1;
      else begin
        waits++;
        if (waits > 50) begin
          failNow("accept_timeout");
          dinValid = 1'b0;
          return;
        end
      end
    end
    @(posedge clk);
    for (int i = 3; i >= 0; i--) bitQ.push_back(word[i]);
    wordQ.push_back(word);
    #1;
    dinValid = 1'b0;
    din      = 4'h0;
  endtask

  task automatic waitDone(output int cycles);
    bit seen;
    cycles = 0;
    seen   = 1'b0;
    while (!seen) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
      else if (cycles > 40) begin
        failNow("done_timeout");
        return;
      end
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || sdoEn) && n < 60);
    if (n >= 60) failNow("idle_timeout");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, c, e0, r0, d0;
    logic [7:0] exp8;
    resetN    = 1'b0;
    din       = 4'h0;
    dinValid  = 1'b0;
    din8      = 8'h00;
    dinValid8 = 1'b0;

    #3;
    checkOutput("reset_sdo", 32'(sdo), 0);
    checkOutput("reset_sdo_en", 32'(sdoEn), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_din_ready", 32'(dinReady), 1);
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    // Single word, first accept on the first edge after reset
    e0 = enCycles; r0 = enRuns; d0 = doneCount;
    applyStimulus(4'b1011, w);
    checkOutput("first_accept_waits", 32'(w), 0);
    checkOutput("single_busy", 32'(busy), 1);
    checkOutput("single_ready", 32'(dinReady), 1);
    waitDone(c);
    checkOutput("single_done_latency", 32'(c), 5);
    checkOutput("single_busy_after", 32'(busy), 0);
    @(posedge clk); #1;
    checkOutput("single_en_cycles", 32'(enCycles - e0), 4);
    checkOutput("single_en_runs", 32'(enRuns - r0), 1);
    checkOutput("single_done_count", 32'(doneCount - d0), 1);
    repeat (2) @(posedge clk); #1;

    // Loopback A then 5 back-to-back
    e0 = enCycles; r0 = enRuns; d0 = doneCount;
    applyStimulus(4'hA, w);
    applyStimulus(4'h5, w);
    waitDone(c);
    checkOutput("loop_first_done", 32'(c), 4);
    waitDone(c);
    checkOutput("loop_second_done", 32'(c), 4);
    @(posedge clk); #1;
    checkOutput("loop_en_cycles", 32'(enCycles - e0), 8);
    checkOutput("loop_en_runs", 32'(enRuns - r0), 1);
    checkOutput("loop_done_count", 32'(doneCount - d0), 2);
    repeat (2) @(posedge clk); #1;

    // Backpressure 3, C, 9
    e0 = enCycles; r0 = enRuns; d0 = doneCount;
    applyStimulus(4'h3, w);
    applyStimulus(4'hC, w);
    checkOutput("bp_c_waits", 32'(w), 0);
    checkOutput("bp_ready_low", 32'(dinReady), 0);
    checkOutput("bp_busy", 32'(busy), 1);
    applyStimulus(4'h9, w);
    checkOutput("bp_9_waits", 32'(w), 3);
    waitIdle();
    @(posedge clk); #1;
    checkOutput("bp_en_cycles", 32'(enCycles - e0), 12);
    checkOutput("bp_en_runs", 32'(enRuns - r0), 1);
    checkOutput("bp_done_count", 32'(doneCount - d0), 3);
    repeat (2) @(posedge clk); #1;

    // Reset after two bits of F
    applyStimulus(4'hF, w);
    @(posedge clk);
    @(posedge clk);
    #2 resetN = 1'b0;
    bitQ.delete();
    wordQ.delete();
    d0 = doneCount;
    #1;
    checkOutput("midrst_sdo", 32'(sdo), 0);
    checkOutput("midrst_sdo_en", 32'(sdoEn), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_ready", 32'(dinReady), 1);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    repeat (3) @(posedge clk); #1;
    checkOutput("midrst_no_done", 32'(doneCount - d0), 0);
    applyStimulus(4'h6, w);
    waitDone(c);
    checkOutput("midrst_next_latency", 32'(c), 5);
    repeat (2) @(posedge clk); #1;

    // Two words with a three-cycle idle gap
    e0 = enCycles; r0 = enRuns; d0 = doneCount;
    applyStimulus(4'h9, w);
    waitDone(c);
    @(posedge clk);
    @(posedge clk); #1;
    applyStimulus(4'h4, w);
    waitDone(c);
    checkOutput("gap_second_latency", 32'(c), 5);
    @(posedge clk); #1;
    checkOutput("gap_en_cycles", 32'(enCycles - e0), 8);
    checkOutput("gap_en_runs", 32'(enRuns - r0), 2);
    checkOutput("gap_done_count", 32'(doneCount - d0), 2);

    // WIDTH=8 instance, 8'h96
    exp8      = 8'h96;
    din8      = 8'h96;
    dinValid8 = 1'b1;
    @(negedge clk);
    checkOutput("w8_ready", 32'(dinReady8), 1);
    @(posedge clk); #1;
    dinValid8 = 1'b0;
    din8      = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      checkOutput("w8_sdo", 32'(sdo8), 32'(exp8[i]));
      checkOutput("w8_sdo_en", 32'(sdoEn8), 1);
      checkOutput("w8_early_done", 32'(done8), 0);
    end
    @(negedge clk);
    checkOutput("w8_done_cycle9", 32'(done8), 1);
    checkOutput("w8_sdo_en_off", 32'(sdoEn8), 0);
    @(negedge clk);
    checkOutput("w8_done_pulse", 32'(done8), 0);
    checkOutput("w8_busy_off", 32'(busy8), 0);

    checkOutput("bitq_drained", 32'(bitQ.size()), 0);
    checkOutput("wordq_drained", 32'(wordQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
